piso_serializer_8bit: RTL and testbench
=======================================

PISO_SERIALIZER_8BIT -- requirements
Module: piso_serializer_8bit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the parallel word width in bits, legal range 2..32.
REQ-002 The block SHALL have parameter MSB_FIRST, default 1, where 1 means MSB is shifted first and 0 means LSB is shifted first.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port data_in, input, WIDTH bits: the parallel word from the upstream PIPO register output.
REQ-006 The block SHALL have port load, input, 1 bit: capture request, accepted only when ready=1.
REQ-007 The block SHALL have port ready, output, 1 bit: high when idle and able to accept a word.
REQ-008 The block SHALL have port serial_out, output, 1 bit: the current serial bit.
REQ-009 The block SHALL have port serial_valid, output, 1 bit: high while serial_out carries a frame bit.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse marking frame completion.

Function
REQ-011 The block SHALL drive all outputs from registers, with no combinational path from inputs to outputs.
REQ-012 The FSM SHALL have states IDLE, SHIFT and PARITY, where PARITY exists only when the macro is defined.
REQ-013 In IDLE: ready=1, serial_valid=0, serial_out=0; a rising edge with load=1 SHALL capture data_in into the shift register, clear the bit counter and enter SHIFT.
REQ-014 The first frame bit SHALL appear on serial_out, with serial_valid=1, in the cycle immediately after the capturing edge (latency 1).
REQ-015 In SHIFT: one bit per cycle, order per MSB_FIRST; the counter increments each edge; ready=0.
REQ-016 After exactly WIDTH data bits, the FSM SHALL enter PARITY if enabled, otherwise IDLE.
REQ-017 On the return to IDLE, done SHALL be 1 for exactly one cycle, concurrent with ready=1 and serial_valid=0.
REQ-018 load while ready=0 SHALL be ignored, and data_in changes mid-frame SHALL NOT affect the frame in flight.
REQ-019 load held high continuously SHALL start the next frame on the edge that ends the done cycle, so frames are separated by one idle cycle.
REQ-020 The counter SHALL be $clog2(WIDTH)+1 bits wide, SHALL never wrap within a frame, and SHALL be cleared on every capture.

Reset
REQ-021 reset=1 SHALL force, asynchronously: state=IDLE, shift register=0, counter=0, ready=1, serial_out=0, serial_valid=0, done=0.
REQ-022 Reset asserted mid-frame SHALL abort the frame with no done pulse, and no partial bits SHALL be emitted after release.
REQ-023 After reset deasserts, the first rising edge with load=1 SHALL be accepted.

Configuration
REQ-024 Macro PISO_PARITY_EN, when defined, SHALL append one even-parity bit (XOR of the captured word) after the data bits: serial_valid=1 for that cycle, frame length WIDTH+1, done following the parity cycle.
REQ-025 When PISO_PARITY_EN is undefined, the PARITY state and parity logic SHALL be absent and the frame length SHALL be WIDTH.

Verification
REQ-026 A bench SHALL cover: WIDTH=8, MSB_FIRST=1, load with 0xA5 -> serial_out 1,0,1,0,0,1,0,1 on cycles 1..8, serial_valid high for 8 cycles, done=1 on cycle 9, ready=1 from cycle 9.
REQ-027 A bench SHALL cover: MSB_FIRST=0, load with 0x01 -> serial_out 1,0,0,0,0,0,0,0, then done.
REQ-028 A bench SHALL cover: PISO_PARITY_EN defined, 0xA5 -> parity bit 0 on cycle 9 and done on cycle 10; 0x07 -> parity bit 1.
REQ-029 A bench SHALL cover: load with 0x3C, then load with 0xFF on cycle 3 -> the 0xFF is ignored and the output stream is exactly 0x3C.
REQ-030 A bench SHALL cover: reset asserted after 3 bits of 0xF0 -> outputs go to their reset values immediately with no done pulse; a new load with 0x81 after release serializes correctly.
REQ-031 A bench SHALL cover: load held high with data_in 0x55 -> back-to-back frames each of 8 valid cycles, separated by a single done/idle cycle.

Source files
------------

// File: rtl/piso_serializer_8bit.sv
// Purpose: parallel-in serial-out shifter; captures a WIDTH-bit word and emits it one bit per clock.
// Latency: first frame bit on serial_out the cycle after the capturing edge; done pulses after the last bit.
// Backpressure: ready=0 while a frame is in flight; load is ignored then, and data_in is only sampled at capture.
// Optional feature: define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer_8bit #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

    state_t           state_q, state_n;
    logic [WIDTH-1:0] sreg_q, sreg_n;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic             ready_q, ready_n;
    logic             so_q, so_n;
    logic             sv_q, sv_n;
    logic             done_q, done_n;
    logic [WIDTH-1:0] shifted;
`ifdef PISO_PARITY_EN
    logic             par_q, par_n;
`endif

    // The bit currently due out always sits at the "head" end of the word.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    // Drop the bit just emitted so the next one moves to the head position.
    always_comb begin
        shifted = (MSB_FIRST != 0) ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_n;
    end

    // Next-state and next-output decode; every output is the registered copy of these.
    always_comb begin
        state_n = state_q;
        sreg_n  = sreg_q;
        cnt_n   = cnt_q;
        ready_n = ready_q;
        so_n    = 1'b0;
        sv_n    = 1'b0;
        done_n  = 1'b0;
`ifdef PISO_PARITY_EN
        par_n   = par_q;
`endif
        case (state_q)
            IDLE: begin
                ready_n = 1'b1;
                if (load) begin
                    sreg_n  = data_in;
                    cnt_n   = '0;
                    state_n = SHIFT;
                    ready_n = 1'b0;
                    so_n    = head_bit(data_in);
                    sv_n    = 1'b1;
`ifdef PISO_PARITY_EN
                    par_n   = ^data_in;
`endif
                end
            end
            SHIFT: begin
                // cnt_q counts bits already shown; it reaches WIDTH at most, so it never wraps.
                cnt_n   = cnt_q + CW'(1);
                ready_n = 1'b0;
                if (cnt_q == LAST_BIT) begin
`ifdef PISO_PARITY_EN
                    state_n = PARITY;
                    so_n    = par_q;
                    sv_n    = 1'b1;
`else
                    state_n = IDLE;
                    ready_n = 1'b1;
                    done_n  = 1'b1;
`endif
                end else begin
                    sreg_n = shifted;
                    so_n   = head_bit(shifted);
                    sv_n   = 1'b1;
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                state_n = IDLE;
                ready_n = 1'b1;
                done_n  = 1'b1;
            end
`endif
            default: begin
                state_n = IDLE;
                ready_n = 1'b1;
            end
        endcase
    end

    // Datapath and output registers; reset aborts any frame silently.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sreg_q  <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            so_q    <= 1'b0;
            sv_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            sreg_q  <= sreg_n;
            cnt_q   <= cnt_n;
            ready_q <= ready_n;
            so_q    <= so_n;
            sv_q    <= sv_n;
            done_q  <= done_n;
        end
    end

`ifdef PISO_PARITY_EN
    // Parity of the captured word, held for the whole frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) par_q <= 1'b0;
        else       par_q <= par_n;
    end
`endif

    assign ready        = ready_q;
    assign serial_out   = so_q;
    assign serial_valid = sv_q;
    assign done         = done_q;

endmodule

// File: tb/tb_piso_serializer_8bit.sv
module tb_piso_serializer_8bit;

`ifdef PISO_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FLEN = 8 + PAR;

    logic       clock;
    logic       reset;
    logic [7:0] din [2];
    logic       load_s [2];
    logic       rdy [2];
    logic       so [2];
    logic       sv [2];
    logic       dn [2];

    int exp_q [2][$];
    int total;
    int passed;
    logic last_par;

    // Instance 0 shifts MSB first, instance 1 LSB first.
    piso_serializer_8bit #(.WIDTH(8), .MSB_FIRST(1)) dut0 (
        .clock(clock), .reset(reset), .data_in(din[0]), .load(load_s[0]),
        .ready(rdy[0]), .serial_out(so[0]), .serial_valid(sv[0]), .done(dn[0])
    );
    piso_serializer_8bit #(.WIDTH(8), .MSB_FIRST(0)) dut1 (
        .clock(clock), .reset(reset), .data_in(din[1]), .load(load_s[1]),
        .ready(rdy[1]), .serial_out(so[1]), .serial_valid(sv[1]), .done(dn[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endfunction

    // Monitor: every valid bit or done pulse must match the head of the expected queue.
    always @(negedge clock) begin : monitor
        int got;
        int e;
        for (int d = 0; d < 2; d++) begin
            if (sv[d] || dn[d]) begin
                got = dn[d] ? 2 : int'(so[d]);
                if (exp_q[d].size() == 0) begin
                    chk($sformatf("sb_unexpected_d%0d", d), got, -1);
                end else begin
                    e = exp_q[d].pop_front();
                    chk($sformatf("sb_d%0d", d), got, e);
                end
                if (dn[d]) chk($sformatf("done_ready_novalid_d%0d", d), {30'd0, rdy[d], sv[d]}, 2);
            end
        end
    end

    // Expected stream: seq[7] is the first bit out, then optional parity, then the done marker (2).
    task automatic push_frame(input int d, input logic [7:0] seq, input logic par);
        for (int i = 7; i >= 0; i--) exp_q[d].push_back(int'(seq[i]));
`ifdef PISO_PARITY_EN
        exp_q[d].push_back(int'(par));
`else
        last_par = par;
`endif
        exp_q[d].push_back(2);
    endtask

    task automatic load_frame(input int d, input logic [7:0] data, input logic [7:0] seq, input logic par);
        int n = 0;
        while (!rdy[d] && n < 200) begin
            @(posedge clock); #2;
            n++;
        end
        chk($sformatf("ready_before_load_d%0d", d), int'(rdy[d]), 1);
        push_frame(d, seq, par);
        din[d] = data;
        load_s[d] = 1'b1;
        @(posedge clock); #2;
        load_s[d] = 1'b0;
        din[d] = ~data;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0 || !rdy[0] || !rdy[1]) && n < 300) begin
            @(negedge clock);
            n++;
        end
        chk("idle_reached", int'(n < 300), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, int'(rdy[0]), 1);
        chk({tag, "_serial_out"}, int'(so[0]), 0);
        chk({tag, "_serial_valid"}, int'(sv[0]), 0);
        chk({tag, "_done"}, int'(dn[0]), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        total = 0;
        passed = 0;
        last_par = 1'b0;
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            din[d] = 8'h00;
            load_s[d] = 1'b0;
        end

        // Reset state.
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;

        // 0xA5 MSB first, exact cycle timing; load on the first edge after release.
        push_frame(0, 8'b10100101, 1'b0);
        din[0] = 8'hA5;
        load_s[0] = 1'b1;
        @(posedge clock); #2;
        load_s[0] = 1'b0;
        din[0] = 8'h00;
        @(negedge clock);
        chk("a5_cycle1_valid", int'(sv[0]), 1);
        chk("a5_cycle1_bit", int'(so[0]), 1);
        chk("a5_cycle1_ready", int'(rdy[0]), 0);
        repeat (FLEN - 1) @(negedge clock);
        chk("a5_last_valid", int'(sv[0]), 1);
        @(negedge clock);
        chk("a5_done_cycle", int'(dn[0]), 1);
        chk("a5_done_ready", int'(rdy[0]), 1);
        chk("a5_done_novalid", int'(sv[0]), 0);
        @(negedge clock);
        chk("a5_done_one_cycle", int'(dn[0]), 0);
        chk("a5_ready_after", int'(rdy[0]), 1);

        // LSB-first 0x01 and MSB-first 0x07 (parity 1) overlapping.
        load_frame(1, 8'h01, 8'b10000000, 1'b1);
        load_frame(0, 8'h07, 8'b00000111, 1'b1);
        wait_idle();
        load_frame(1, 8'h0D, 8'b10110000, 1'b1);
        wait_idle();

        // 0x3C with an attempted 0xFF load on cycle 3.
        load_frame(0, 8'h3C, 8'b00111100, 1'b0);
        @(posedge clock);
        @(posedge clock); #2;
        din[0] = 8'hFF;
        load_s[0] = 1'b1;
        @(posedge clock); #2;
        load_s[0] = 1'b0;
        chk("midframe_load_ready", int'(rdy[0]), 0);
        wait_idle();

        // Reset after 3 bits of 0xF0, then 0x81.
        load_frame(0, 8'hF0, 8'b11110000, 1'b0);
        repeat (3) @(posedge clock);
        #2 reset = 1'b1;
        exp_q[0].delete();
        #1;
        check_reset_outputs("midframe_reset");
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        load_frame(0, 8'h81, 8'b10000001, 1'b0);
        @(negedge clock);
        chk("post_reset_accept", int'(sv[0]), 1);
        wait_idle();

        // load held high with 0x55: three back-to-back frames, one done/idle cycle apart.
        for (int f = 0; f < 3; f++) push_frame(0, 8'b01010101, 1'b0);
        @(posedge clock); #2;
        din[0] = 8'h55;
        load_s[0] = 1'b1;
        bad = 0;
        for (int k = 1; k <= 3 * (FLEN + 1); k++) begin
            @(posedge clock); #2;
            if (k - 1 == 2 * (FLEN + 1)) load_s[0] = 1'b0;
            @(negedge clock);
            if (sv[0] != ((k % (FLEN + 1)) != 0)) bad++;
            if (dn[0] != ((k % (FLEN + 1)) == 0)) bad++;
        end
        chk("b2b_timing_errors", bad, 0);
        wait_idle();

        chk("queue0_drained", exp_q[0].size(), 0);
        chk("queue1_drained", exp_q[1].size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
